imem_arbiter: RTL and testbench

Arbitrates the single-port, one-cycle-latency instruction memory between the core fetch path and a program loader/debug port.
- Fetch has priority by default.
- A starvation counter guarantees loader progress.
- A lock mode gives the loader exclusive access during image download.
- Read responses are routed back to the requester granted one cycle earlier.

---
 rtl/imem_arbiter.sv | 125 ++++++++++++
 tb/tb_imem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: fetch has priority, the loader gets a forced grant after
// MAX_WAIT denied cycles, and a lock mode gives the loader exclusive access. Optional counters: IMEM_ARB_PERF_CNT_EN.
module imem_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          f_req_i,
   input  logic [AW-1:0] f_addr_i,
   output logic          f_gnt_o,
   output logic          f_rvalid_o,
   output logic [DW-1:0] f_rdata_o,
   input  logic          l_req_i,
   input  logic          l_we_i,
   input  logic          l_lock_i,
   input  logic [AW-1:0] l_addr_i,
   input  logic [DW-1:0] l_wdata_i,
   output logic          l_gnt_o,
   output logic          l_rvalid_o,
   output logic [DW-1:0] l_rdata_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i
`ifdef IMEM_ARB_PERF_CNT_EN
  ,output logic [31:0]   conflict_cnt_o
  ,output logic [31:0]   force_cnt_o
`endif
);

   typedef enum logic {
      FETCH_PRI   = 1'b0,
      LOADER_LOCK = 1'b1
   } state_t;

   localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

   state_t        state;
   logic [7:0]    wait_cnt;
   logic          resp_valid_q;
   logic          resp_owner_q;
   logic          f_gnt;
   logic          l_gnt;
   logic [AW-1:0] sel_addr;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
      if (!reset) begin
         case (state)
            FETCH_PRI: begin
               f_gnt = f_req_i && (wait_cnt < MAX_W);
               l_gnt = l_req_i && (!f_req_i || (wait_cnt == MAX_W));
            end
            LOADER_LOCK: l_gnt = l_req_i;
            default: ;
         endcase
      end
   end

   always_comb begin
      sel_addr = '0;
      if (l_gnt)
         sel_addr = l_addr_i;
      else if (f_gnt)
         sel_addr = f_addr_i;
   end

   assign f_gnt_o     = f_gnt;
   assign l_gnt_o     = l_gnt;
   assign mem_req_o   = f_gnt | l_gnt;
   assign mem_we_o    = l_gnt & l_we_i;
   assign mem_addr_o  = sel_addr & ~AW'(3);
   assign mem_wdata_o = l_gnt ? l_wdata_i : '0;

   assign f_rvalid_o  = resp_valid_q & ~resp_owner_q;
   assign l_rvalid_o  = resp_valid_q & resp_owner_q;
   assign f_rdata_o   = mem_rdata_i;
   assign l_rdata_o   = mem_rdata_i;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= FETCH_PRI;
         wait_cnt     <= '0;
         resp_valid_q <= 1'b0;
         resp_owner_q <= 1'b0;
      end else begin
         case (state)
            FETCH_PRI:   if (l_gnt && l_lock_i) state <= LOADER_LOCK;
            LOADER_LOCK: if (!l_lock_i)         state <= FETCH_PRI;
            default:                            state <= FETCH_PRI;
         endcase

         if (l_req_i && !l_gnt)
            wait_cnt <= (wait_cnt == MAX_W) ? wait_cnt : wait_cnt + 8'd1;
         else
            wait_cnt <= '0;

         resp_valid_q <= (f_gnt | l_gnt) & ~(l_gnt & l_we_i);
         resp_owner_q <= l_gnt;
      end
   end

`ifdef IMEM_ARB_PERF_CNT_EN
   logic forced;
   // A loader grant in FETCH_PRI while fetch is requesting can only come from starvation.
   assign forced = (state == FETCH_PRI) && f_req_i && l_gnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         conflict_cnt_o <= '0;
         force_cnt_o    <= '0;
      end else begin
         if (f_req_i && l_req_i) conflict_cnt_o <= conflict_cnt_o + 32'd1;
         if (forced)             force_cnt_o    <= force_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: priority, starvation, lock, response routing and reset.
// Perf-counter checks are compiled in when IMEM_ARB_PERF_CNT_EN is defined.
module tb_imem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [31:0] KEY = 32'hC0DE_0000;

   logic          clk = 1'b0;
   logic          reset;
   logic          f_req_i, f_gnt_o, f_rvalid_o;
   logic [AW-1:0] f_addr_i;
   logic [DW-1:0] f_rdata_o;
   logic          l_req_i, l_we_i, l_lock_i, l_gnt_o, l_rvalid_o;
   logic [AW-1:0] l_addr_i;
   logic [DW-1:0] l_wdata_i, l_rdata_o;
   logic          mem_req_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i;
`ifdef IMEM_ARB_PERF_CNT_EN
   logic [31:0]   conflict_cnt_o, force_cnt_o;
   logic [31:0]   conf0, force0;
`endif

   int total = 0;
   int bad   = 0;

   imem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
      .clk(clk), .reset(reset),
      .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o),
      .f_rvalid_o(f_rvalid_o), .f_rdata_o(f_rdata_o),
      .l_req_i(l_req_i), .l_we_i(l_we_i), .l_lock_i(l_lock_i),
      .l_addr_i(l_addr_i), .l_wdata_i(l_wdata_i), .l_gnt_o(l_gnt_o),
      .l_rvalid_o(l_rvalid_o), .l_rdata_o(l_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
`ifdef IMEM_ARB_PERF_CNT_EN
     ,.conflict_cnt_o(conflict_cnt_o), .force_cnt_o(force_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   // Memory model: read data is the aligned address xor KEY, one cycle after the strobe.
   initial mem_rdata_i = '0;
   always @(posedge clk)
      if (mem_req_o && !mem_we_o) mem_rdata_i <= mem_addr_o ^ KEY;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   initial begin
      logic          exp_l, prev_l;
      logic [31:0]   fa, la, prev_addr;

      reset = 1'b1;
      f_req_i = 1'b1; f_addr_i = 32'h44;
      l_req_i = 1'b1; l_we_i = 1'b1; l_lock_i = 1'b0; l_addr_i = 32'h88; l_wdata_i = 32'h1234;

      // Reset: all grants and strobes low even with both requesters active
      @(negedge clk); #1;
      check("rst_fgnt", f_gnt_o, 0);
      check("rst_lgnt", l_gnt_o, 0);
      check("rst_memreq", mem_req_o, 0);
      check("rst_memwe", mem_we_o, 0);
      check("rst_addr", mem_addr_o, 0);
      check("rst_frv", f_rvalid_o, 0);
      check("rst_lrv", l_rvalid_o, 0);
      @(negedge clk);
      reset = 1'b0; f_req_i = 1'b0; l_req_i = 1'b0; l_we_i = 1'b0;

      // Back-to-back fetch reads 0x0, 0x4, 0x8
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         f_req_i = 1'b1; f_addr_i = 32'(4 * i);
         #1;
         check("t1_fgnt", f_gnt_o, 1);
         check("t1_lgnt", l_gnt_o, 0);
         check("t1_addr", mem_addr_o, 64'(4 * i));
         check("t1_frv", f_rvalid_o, (i > 0) ? 64'd1 : 64'd0);
         check("t1_lrv", l_rvalid_o, 0);
         if (i > 0) check("t1_rdata", f_rdata_o, 32'(4 * (i - 1)) ^ KEY);
      end
      @(negedge clk);
      f_req_i = 1'b0;
      #1;
      check("t1_frv_last", f_rvalid_o, 1);
      check("t1_rdata_last", f_rdata_o, 32'h8 ^ KEY);
      check("t1_lrv_last", l_rvalid_o, 0);
      check("t1_idle_req", mem_req_o, 0);
      @(negedge clk); #1;
      check("t1_frv_clear", f_rvalid_o, 0);

      // Starvation: loader write denied 4 cycles, forced on the 5th (misaligned 0x103 -> 0x100)
      @(negedge clk);
      f_req_i = 1'b1; f_addr_i = 32'h20;
      l_req_i = 1'b1; l_we_i = 1'b1; l_addr_i = 32'h103; l_wdata_i = 32'hDEADBEEF;
      for (int c = 0; c < 4; c++) begin
         #1;
         check("t2_denied", l_gnt_o, 0);
         check("t2_fgnt", f_gnt_o, 1);
         @(negedge clk);
      end
      #1;
      check("t2_lgnt", l_gnt_o, 1);
      check("t2_fgnt_off", f_gnt_o, 0);
      check("t2_we", mem_we_o, 1);
      check("t2_addr", mem_addr_o, 32'h100);
      check("t2_wdata", mem_wdata_o, 32'hDEADBEEF);
      check("t2_frv", f_rvalid_o, 1);
      @(negedge clk);
      l_req_i = 1'b0; l_we_i = 1'b0;
      #1;
      check("t2_fetch_resume", f_gnt_o, 1);
      check("t2_write_no_lrv", l_rvalid_o, 0);
      check("t2_write_no_frv", f_rvalid_o, 0);

      // Lock: loader enters lock with fetch idle, then 8 writes while fetch requests
      @(negedge clk);
      f_req_i = 1'b0;
      l_req_i = 1'b1; l_we_i = 1'b1; l_lock_i = 1'b1; l_addr_i = 32'h200; l_wdata_i = 32'h0;
      #1;
      check("t3_lock_gnt", l_gnt_o, 1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         f_req_i = 1'b1; f_addr_i = 32'h30;
         l_addr_i = 32'(32'h204 + 4 * k); l_wdata_i = 32'(k);
         #1;
         check("t3_fgnt_blocked", f_gnt_o, 0);
         check("t3_lgnt", l_gnt_o, 1);
         check("t3_addr", mem_addr_o, 64'(32'h204 + 4 * k));
      end
      @(negedge clk);
      l_lock_i = 1'b0; l_addr_i = 32'h230;
      #1;
      check("t3_unlock_lgnt", l_gnt_o, 1);
      check("t3_unlock_fgnt", f_gnt_o, 0);
      @(negedge clk);
      l_req_i = 1'b0; l_we_i = 1'b0;
      #1;
      check("t3_fetch_after", f_gnt_o, 1);
      check("t3_fetch_addr", mem_addr_o, 32'h30);

      // Contention with reads: grant pattern F F F F L F F F F L, rvalid routed to owner
      fa = 32'h300; la = 32'h400; prev_l = 1'b0; prev_addr = 32'h30;
      for (int c = 0; c < 10; c++) begin
         exp_l = (c == 4) || (c == 9);
         @(negedge clk);
         f_req_i = 1'b1; f_addr_i = fa;
         l_req_i = 1'b1; l_we_i = 1'b0; l_addr_i = la;
`ifdef IMEM_ARB_PERF_CNT_EN
         if (c == 0) begin conf0 = conflict_cnt_o; force0 = force_cnt_o; end
`endif
         #1;
         check("t4_fgnt", f_gnt_o, !exp_l);
         check("t4_lgnt", l_gnt_o, exp_l);
         check("t4_frv", f_rvalid_o, !prev_l);
         check("t4_lrv", l_rvalid_o, prev_l);
         check("t4_rdata", prev_l ? l_rdata_o : f_rdata_o, prev_addr ^ KEY);
         prev_l = exp_l;
         prev_addr = exp_l ? la : fa;
         if (exp_l) la = la + 32'd4; else fa = fa + 32'd4;
      end
      @(negedge clk);
      f_req_i = 1'b0; l_req_i = 1'b0;
      #1;
      check("t4_lrv_last", l_rvalid_o, 1);
      check("t4_frv_last", f_rvalid_o, 0);
      check("t4_lrdata_last", l_rdata_o, prev_addr ^ KEY);
`ifdef IMEM_ARB_PERF_CNT_EN
      check("perf_conflict", conflict_cnt_o - conf0, 10);
      check("perf_force", force_cnt_o - force0, 2);
`endif

      // Reset the cycle after a granted fetch read: response discarded
      @(negedge clk);
      f_req_i = 1'b1; f_addr_i = 32'h40;
      #1;
      check("t5_fgnt", f_gnt_o, 1);
      @(negedge clk);
      reset = 1'b1; l_req_i = 1'b1;
      #1;
      check("t5_frv_killed", f_rvalid_o, 0);
      check("t5_fgnt_rst", f_gnt_o, 0);
      check("t5_lgnt_rst", l_gnt_o, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("t5_first_fetch", f_gnt_o, 1);
      check("t5_first_lgnt", l_gnt_o, 0);
      check("t5_frv_after", f_rvalid_o, 0);

      // Reset while locked must return to FETCH_PRI
      @(negedge clk);
      f_req_i = 1'b0; l_req_i = 1'b1; l_we_i = 1'b1; l_lock_i = 1'b1; l_addr_i = 32'h500;
      #1;
      check("t6_lock_gnt", l_gnt_o, 1);
      @(negedge clk);
      f_req_i = 1'b1;
      #1;
      check("t6_locked", f_gnt_o, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("t6_fetch_pri", f_gnt_o, 1);
      check("t6_lgnt", l_gnt_o, 0);
`ifdef IMEM_ARB_PERF_CNT_EN
      check("perf_conflict_rst", conflict_cnt_o, 0);
      check("perf_force_rst", force_cnt_o, 0);
`endif

      @(negedge clk);
      f_req_i = 1'b0; l_req_i = 1'b0; l_we_i = 1'b0; l_lock_i = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
